tick_timer_bank: RTL and testbench

Multi-channel programmable millisecond timer bank for the game core. A shared prescaler divides `clk` into a 1 ms strobe. Each of `NUM_CH` independent channels counts a programmable number of those strobes and fires a one-cycle tick in periodic or one-shot mode. It replaces single fixed-rate divider blocks: game logic (ghost movement, animation, power-pellet countdown, sound timing) loads a period per channel and consumes the single-cycle ticks.

---
 rtl/tick_timer_bank_if.sv | 31 +++
 rtl/tick_timer_bank.sv | 125 ++++++++++++
 tb/tb_tick_timer_bank.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tick_timer_bank_if.sv
// Bus bundle for tick_timer_bank.
// Control side: en (global run enable), load/stop (per-channel strobes), periodic (mode per
// channel, sampled on load), period (shared period bus in ms).
// Status side: ms_tick (1 ms strobe), tick (per-channel expiry pulse), sq (per-channel square
// wave), active (channel running), done (one-shot expired, sticky).
// master drives the control side; slave is the timer bank.
interface tick_timer_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              en;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] periodic;
  logic [CNT_W-1:0]  period;
  logic [NUM_CH-1:0] stop;
  logic              ms_tick;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] done;

  modport master (
    output en, load, periodic, period, stop,
    input  ms_tick, tick, sq, active, done
  );

  modport slave (
    input  en, load, periodic, period, stop,
    output ms_tick, tick, sq, active, done
  );
endinterface

// File: rtl/tick_timer_bank.sv
// Multi-channel millisecond timer bank.
// A shared prescaler divides clk into a one-cycle 1 ms strobe (ms_tick). Each channel counts a
// loaded number of strobes and emits a one-cycle tick, either periodically (auto-reload) or
// once (one-shot, then sticky done).
// Ports: clk, rst (async, active-high), bus (tick_timer_bank_if slave: en, load, periodic,
// period, stop in; ms_tick, tick, sq, active, done out). All outputs are registered.
module tick_timer_bank #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  tick_timer_bank_if.slave bus
);

  localparam int unsigned PcntW = $clog2(PRESCALE);
  localparam logic [PcntW-1:0] PcntMax = PcntW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} ch_state_e;

  logic [PcntW-1:0]              pcnt_q, pcnt_d;
  logic                          ms_tick_q, ms_tick_d;
  ch_state_e [NUM_CH-1:0]        state_q, state_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  rld_q, rld_d;
  logic [NUM_CH-1:0]             mode_q, mode_d;
  logic [NUM_CH-1:0]             tick_q, tick_d;
  logic [NUM_CH-1:0]             sq_q, sq_d;
  logic [NUM_CH-1:0]             active_q, active_d;
  logic [NUM_CH-1:0]             done_q, done_d;

  // Prescaler: holds (and suppresses the strobe) while en is low.
  always_comb begin
    pcnt_d    = pcnt_q;
    ms_tick_d = 1'b0;
    if (bus.en) begin
      if (pcnt_q == PcntMax) begin
        pcnt_d    = '0;
        ms_tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PcntW'(1);
      end
    end
  end

  // Channels: load > stop > strobe-driven countdown.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rld_d    = rld_q;
    mode_d   = mode_q;
    done_d   = done_q;
    sq_d     = sq_q;
    tick_d   = '0;
    active_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.load[i]) begin
        done_d[i] = 1'b0;
        if (bus.period != '0) begin
          cnt_d[i]   = bus.period - CNT_W'(1);
          rld_d[i]   = bus.period - CNT_W'(1);
          mode_d[i]  = bus.periodic[i];
          state_d[i] = StRun;
        end else begin
          cnt_d[i]   = '0;
          state_d[i] = StIdle;
        end
      end else if (bus.stop[i]) begin
        state_d[i] = StIdle;
        done_d[i]  = 1'b0;
        cnt_d[i]   = '0;
      end else if (state_q[i] == StRun && ms_tick_q) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
          if (mode_q[i]) begin
            cnt_d[i] = rld_q[i];
          end else begin
            state_d[i] = StDone;
            done_d[i]  = 1'b1;
          end
        end
      end
      active_d[i] = (state_d[i] == StRun);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q    <= '0;
      ms_tick_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
      end
      cnt_q     <= '0;
      rld_q     <= '0;
      mode_q    <= '0;
      tick_q    <= '0;
      sq_q      <= '0;
      active_q  <= '0;
      done_q    <= '0;
    end else begin
      pcnt_q    <= pcnt_d;
      ms_tick_q <= ms_tick_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rld_q     <= rld_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign bus.ms_tick = ms_tick_q;
  assign bus.tick    = tick_q;
  assign bus.sq      = sq_q;
  assign bus.active  = active_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_tick_timer_bank.sv
// Directed bench for tick_timer_bank with PRESCALE=4. Edge numbers below count rising clk
// edges after reset release; outputs are sampled 1 time unit after each edge.
module tb_tick_timer_bank;

  localparam int unsigned Prescale = 4;
  localparam int unsigned NumCh    = 4;
  localparam int unsigned CntW     = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   now_e;
  int   tcnt [NumCh];
  int   c2_snap;
  int   snap [NumCh];

  tick_timer_bank_if #(.NUM_CH(NumCh), .CNT_W(CntW)) bus ();

  tick_timer_bank #(
    .PRESCALE (Prescale),
    .NUM_CH   (NumCh),
    .CNT_W    (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < NumCh; i++) begin
      if (bus.tick[i] === 1'b1) tcnt[i] = tcnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, now_e);
    end
  endtask

  task automatic goto(input int tgt);
    while (now_e < tgt) begin
      @(posedge clk);
      #1;
      now_e++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    now_e = 0;
    for (int i = 0; i < NumCh; i++) tcnt[i] = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.load     = '0;
    bus.periodic = '0;
    bus.period   = '0;
    bus.stop     = '0;
    #22;
    check("reset_outs", {bus.ms_tick, bus.tick, bus.sq, bus.active, bus.done}, 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bus.en = 1'b1;
    now_e  = 0;

    // Prescaler strobes at 4, 8, 12.
    goto(3);  check("ms@3", bus.ms_tick, 1'b0);
    goto(4);  check("ms@4", bus.ms_tick, 1'b1);
    goto(5);  check("ms@5", bus.ms_tick, 1'b0);
    goto(8);  check("ms@8", bus.ms_tick, 1'b1);
    goto(12); check("ms@12", bus.ms_tick, 1'b1);

    // ch0 periodic, period 3: ticks at 25, 37, 49, 61, ...
    bus.load = 4'b0001; bus.period = 16'd3; bus.periodic = 4'b0001;
    goto(13);
    bus.load = '0;
    check("ch0_active", bus.active, 4'b0001);
    goto(24); check("ch0_tick@24", bus.tick[0], 1'b0);
    goto(25); check("ch0_tick@25", bus.tick[0], 1'b1);
    check("ch0_sq@25", bus.sq[0], 1'b1);
    check("ch0_done@25", bus.done[0], 1'b0);
    goto(26); check("ch0_tick@26", bus.tick[0], 1'b0);
    goto(37); check("ch0_tick@37", bus.tick[0], 1'b1);
    check("ch0_sq@37", bus.sq[0], 1'b0);

    // ch1 one-shot, period 2: single tick at 45.
    bus.load = 4'b0010; bus.period = 16'd2; bus.periodic = 4'b0000;
    goto(38);
    bus.load = '0;
    goto(44);
    check("ch1_tick@44", bus.tick[1], 1'b0);
    check("ch1_active@44", bus.active[1], 1'b1);
    goto(45);
    check("ch1_tick@45", bus.tick[1], 1'b1);
    check("ch1_done@45", bus.done[1], 1'b1);
    check("ch1_active@45", bus.active[1], 1'b0);

    // ch2 periodic, period 1: ticks at 49, 53; reload with period 2 on the 53 expiry.
    bus.load = 4'b0100; bus.period = 16'd1; bus.periodic = 4'b0100;
    goto(46);
    bus.load = '0;
    goto(49); check("ch2_tick@49", bus.tick[2], 1'b1);
    goto(52);
    bus.load = 4'b0100; bus.period = 16'd2; bus.periodic = 4'b0100;
    goto(53);
    bus.load = '0;
    check("ch2_collide@53", bus.tick[2], 1'b0);
    goto(57); check("ch2_tick@57", bus.tick[2], 1'b0);
    goto(61); check("ch2_tick@61", bus.tick[2], 1'b1);

    // ch3 load and stop together: load wins.
    bus.load = 4'b1000; bus.stop = 4'b1000; bus.period = 16'd5; bus.periodic = 4'b0000;
    goto(62);
    bus.load = '0; bus.stop = '0;
    check("ch3_load_wins", bus.active[3], 1'b1);

    // ch2 load with period 0: goes idle, never ticks again.
    bus.load = 4'b0100; bus.period = 16'd0;
    goto(63);
    bus.load = '0;
    check("ch2_p0_active", bus.active[2], 1'b0);
    c2_snap = tcnt[2];

    // Pause 10 cycles (edges 64..73); ch0 tick moves from 73 to 83.
    bus.en = 1'b0;
    goto(65);
    bus.stop = 4'b1000;
    goto(66);
    bus.stop = '0;
    check("ch3_stop_paused", {bus.active[3], bus.done[3]}, 2'b00);
    goto(68); check("pause_ms@68", bus.ms_tick, 1'b0);
    goto(73);
    check("pause_tick@73", bus.tick[0], 1'b0);
    bus.en = 1'b1;
    goto(74); check("resume_ms@74", bus.ms_tick, 1'b1);
    goto(82); check("ch0_tick@82", bus.tick[0], 1'b0);
    goto(83); check("ch0_tick@83", bus.tick[0], 1'b1);
    check("ch0_sq@83", bus.sq[0], 1'b1);
    check("ch1_one_tick", tcnt[1], 1);
    check("ch2_no_tick", tcnt[2], c2_snap);

    // All channels running, then async reset mid-period.
    bus.load = 4'b1110; bus.period = 16'd2; bus.periodic = 4'b1110;
    goto(84);
    bus.load = '0;
    check("all_active", bus.active, 4'b1111);
    goto(86);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outs", {bus.ms_tick, bus.tick, bus.sq, bus.active, bus.done}, 32'h0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    now_e = 0;
    for (int i = 0; i < NumCh; i++) snap[i] = tcnt[i];
    goto(3); check("post_rst_ms@3", bus.ms_tick, 1'b0);
    goto(4); check("post_rst_ms@4", bus.ms_tick, 1'b1);
    goto(30);
    check("post_rst_active", bus.active, 4'b0000);
    check("post_rst_ticks", (tcnt[0] - snap[0]) + (tcnt[1] - snap[1]) +
          (tcnt[2] - snap[2]) + (tcnt[3] - snap[3]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
